// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with start-bit glitch rejection,
// framing/parity/overrun detection and a first-word-fall-through receive FIFO.
// Optional parity checking is built when UART_RX_PARITY_EN is defined.
module uart_rx_fifo #(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          baud_tick,
    input  logic                          rx_en,
    input  logic                          uart_rx,
    input  logic                          rd_en,
    input  logic                          err_clr,
    output logic [DATA_W-1:0]             rx_data,
    output logic                          rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_W);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);
    localparam logic          S_LAST = 1'(STOP_BITS - 1);
    localparam logic [AW:0]   C_FULL = (AW + 1)'(FIFO_DEPTH);

    // Reject parameter sets the datapath is not sized for.
    if (DATA_W < 5 || DATA_W > 9 || OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_param_check
        $error("uart_rx_fifo: illegal parameter set");
    end

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t              state, nstate;
    logic                rx_s1, rx_s;
    logic [TW-1:0]       tcnt;
    logic [BW-1:0]       bidx;
    logic [DATA_W-1:0]   shreg;
    logic                sidx;
    logic                stop_bad;
    logic                samp, done, good, fe_set, pe_set;
    logic                push, pop, ov_set;
    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]       wptr, rptr;
    logic [AW:0]         count;
`ifdef UART_RX_PARITY_EN
    logic                par_bad;
    logic                par_miss;
    assign par_miss = rx_s != (^shreg ^ 1'(PARITY_ODD));
`endif

    // Two-flop synchroniser for the asynchronous line; idles high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_s1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_s1 <= uart_rx;
            rx_s  <= rx_s1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= nstate;
    end

    // Next-state logic; only baud ticks move the FSM.
    always_comb begin
        nstate = state;
        case (state)
            IDLE:   if (baud_tick && !rx_s && rx_en) nstate = START;
            START:  if (samp) nstate = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:   if (samp && bidx == B_LAST) nstate = PARITY;
            PARITY: if (samp) nstate = STOP;
`else
            DATA:   if (samp && bidx == B_LAST) nstate = STOP;
`endif
            STOP:   if (done) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Decode sample strobes and frame outcome from state and counters.
    always_comb begin
        samp = 1'b0;
        if (baud_tick) begin
            case (state)
                START:   samp = (tcnt == T_HALF);
                IDLE:    samp = 1'b0;
                default: samp = (tcnt == T_FULL);
            endcase
        end
        done   = samp && state == STOP && sidx == S_LAST;
        fe_set = samp && state == STOP && !rx_s;
`ifdef UART_RX_PARITY_EN
        pe_set = samp && state == PARITY && par_miss;
        good   = done && rx_s && !stop_bad && !par_bad;
`else
        pe_set = 1'b0;
        good   = done && rx_s && !stop_bad;
`endif
    end

    // Bit timing and data capture; the middle of each bit is sampled.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tcnt     <= '0;
            bidx     <= '0;
            shreg    <= '0;
            sidx     <= 1'b0;
            stop_bad <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad  <= 1'b0;
`endif
        end else if (baud_tick) begin
            tcnt <= samp ? '0 : tcnt + 1'b1;
            if (state == IDLE) begin
                tcnt     <= '0;
                bidx     <= '0;
                sidx     <= 1'b0;
                stop_bad <= 1'b0;
`ifdef UART_RX_PARITY_EN
                par_bad  <= 1'b0;
`endif
            end
            if (samp) begin
                case (state)
                    DATA: begin
                        shreg[bidx] <= rx_s;
                        bidx        <= bidx + 1'b1;
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: par_bad <= par_miss;
`endif
                    STOP: begin
                        stop_bad <= stop_bad | ~rx_s;
                        sidx     <= sidx + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // A full FIFO still accepts a word when a pop happens on the same clk.
    assign pop    = rd_en && count != '0;
    assign push   = good && (count != C_FULL || pop);
    assign ov_set = good && !push;

    // FIFO storage; empty entries are masked on the output so no reset needed.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= shreg;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rx_valid = (count != '0);
    assign rx_count = count;
    assign rx_data  = rx_valid ? mem[rptr] : '0;

    // Sticky error flags; a new error beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= (frame_err & ~err_clr) | fe_set;
            overrun   <= (overrun & ~err_clr) | ov_set;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Sticky parity flag, same clear/set priority as the others.
    always_ff @(posedge clk) begin
        if (!reset) parity_err <= 1'b0;
        else        parity_err <= (parity_err & ~err_clr) | pe_set;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: directed scenarios plus random frames,
// checked against a queue-based model of the receive path.
module tb_uart_rx_fifo;

    localparam int DW    = 8;
    localparam int OS    = 16;
    localparam int SB    = 1;
    localparam int DEPTH = 4;
    localparam int PODD  = 0;
    localparam int DIV   = 2;   // clks per baud_tick
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NB     = 1 + DW + PB + SB;
    // Tick index (from start-bit edge) of the final stop-bit sample.
    localparam int DONE_T = 1 + OS / 2 + OS * (DW + PB + SB);

    logic clk = 1'b0, reset = 1'b0, baud_tick = 1'b0, rx_en = 1'b0;
    logic uart_rx = 1'b1, rd_en = 1'b0, err_clr = 1'b0;
    logic [DW-1:0]            rx_data;
    logic                     rx_valid;
    logic [$clog2(DEPTH):0]   rx_count;
    logic                     frame_err, parity_err, overrun;

    int checks = 0, failures = 0;
    logic [DW-1:0] q[$];
    bit m_fe = 0, m_pe = 0, m_ov = 0;

    uart_rx_fifo #(.DATA_W(DW), .OVERSAMPLE(OS), .STOP_BITS(SB),
                   .FIFO_DEPTH(DEPTH), .PARITY_ODD(PODD)) dut (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx_en(rx_en),
        .uart_rx(uart_rx), .rd_en(rd_en), .err_clr(err_clr),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_count(rx_count),
        .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            baud_tick = 1'b1; clk1(); baud_tick = 1'b0;
            repeat (DIV - 1) clk1();
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [DW-1:0] ed;
        ed = (q.size() > 0) ? q[0] : '0;
        chk({tag, ".count"}, 32'(rx_count), q.size());
        chk({tag, ".valid"}, 32'(rx_valid), 32'(q.size() > 0));
        chk({tag, ".data"}, 32'(rx_data), 32'(ed));
        chk({tag, ".frame_err"}, 32'(frame_err), 32'(m_fe));
        chk({tag, ".parity_err"}, 32'(parity_err), 32'(m_pe));
        chk({tag, ".overrun"}, 32'(overrun), 32'(m_ov));
    endtask

    task automatic model_clear();
        q.delete();
        m_fe = 0; m_pe = 0; m_ov = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) clk1();
        model_clear();
        check_all("reset");
        reset = 1'b1;
    endtask

    task automatic do_read(input string tag);
        rd_en = 1'b1; clk1(); rd_en = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
        check_all(tag);
    endtask

    task automatic do_clr(input string tag);
        err_clr = 1'b1; clk1(); err_clr = 1'b0;
        m_fe = 0; m_pe = 0; m_ov = 0;
        check_all(tag);
    endtask

    // Drive one frame; rd/clr are pulsed on the clk of the last stop sample.
    task automatic send(input logic [DW-1:0] d, input bit stop_low, input bit par_flip,
                        input bit rd_done, input bit clr_done,
                        input int en_off_at, input int abort_at);
        logic [15:0] lb;
        bit det, good, ovs;
        det = 0;
        lb = '1;
        lb[0] = 1'b0;
        for (int i = 0; i < DW; i++) lb[1 + i] = d[i];
        if (PB != 0) lb[1 + DW] = (^d) ^ 1'(PODD) ^ par_flip;
        for (int i = 0; i < SB; i++) lb[1 + DW + PB + i] = !stop_low;
        for (int t = 0; t < NB * OS; t++) begin
            if (t == abort_at) begin
                reset = 1'b0; clk1(); clk1(); reset = 1'b1;
                uart_rx = 1'b1;
                model_clear();
                check_all("abort");
                idle(2 * OS);
                return;
            end
            uart_rx = lb[t / OS];
            if (t == en_off_at) rx_en = 1'b0;
            if (t == 1) det = rx_en;
            if (t == DONE_T) begin rd_en = rd_done; err_clr = clr_done; end
            baud_tick = 1'b1; clk1();
            baud_tick = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
            if (t == DONE_T) begin
                good = det && !stop_low && !par_flip;
                ovs = 0;
                if (rd_done && q.size() > 0) void'(q.pop_front());
                if (good) begin
                    if (q.size() < DEPTH) q.push_back(d);
                    else ovs = 1;
                end
                m_fe = (m_fe && !clr_done) || (det && stop_low);
                m_pe = (m_pe && !clr_done) || (det && par_flip);
                m_ov = (m_ov && !clr_done) || ovs;
                check_all("frame");
            end
            repeat (DIV - 1) clk1();
        end
        uart_rx = 1'b1;
        if (stop_low) idle(OS);
    endtask

    initial begin
        logic [DW-1:0] rd;
        bit sl, pf;
        do_reset();
        rx_en = 1'b1;
        idle(4);

        // Single frame, then pop back to empty; extra pop on empty ignored.
        send(8'h5A, 0, 0, 0, 0, -1, -1);
        do_read("pop5a");
        do_read("pop_empty");

        // Start glitch of 4 ticks.
        uart_rx = 1'b0; idle(4); uart_rx = 1'b1; idle(2 * OS);
        check_all("glitch");

        // Low stop bit, then clear.
        send(8'h33, 1, 0, 0, 0, -1, -1);
        do_clr("clr_fe");

        // Five back-to-back frames into a 4-deep FIFO.
        for (int i = 1; i <= 5; i++) send(DW'(i), 0, 0, 0, 0, -1, -1);
        for (int i = 0; i < 4; i++) do_read("drain5");
        do_clr("clr_ov");

        // Fill, then fifth frame lands on a pop clk: no overrun.
        for (int i = 1; i <= 4; i++) send(DW'(8'h10 + i), 0, 0, 0, 0, -1, -1);
        send(8'h15, 0, 0, 1, 0, -1, -1);
        for (int i = 0; i < 4; i++) do_read("drain_simul");

        // New framing error on the same clk as err_clr keeps the flag.
        send(8'h44, 1, 0, 0, 1, -1, -1);
        do_clr("clr_fe2");

        // rx_en dropped mid-frame still completes; disabled start is ignored.
        send(8'hA5, 0, 0, 0, 0, 20, -1);
        send(8'h3C, 0, 0, 0, 0, -1, -1);
        rx_en = 1'b1;
        idle(OS);
        check_all("en_off");

        // Reset mid-frame with data in the FIFO.
        send(8'h77, 0, 0, 0, 0, -1, 70);
        send(8'h81, 0, 0, 0, 0, -1, -1);
        do_read("after_abort");

`ifdef UART_RX_PARITY_EN
        send(8'h07, 0, 1, 0, 0, -1, -1);
        send(8'h07, 0, 0, 0, 0, -1, -1);
        do_read("par_ok");
        do_clr("clr_pe");
`endif

        // Random frames with random reads, clears and errors.
        for (int n = 0; n < 30; n++) begin
            rd = DW'($urandom);
            sl = ($urandom_range(0, 7) == 0);
            pf = (PB != 0) && ($urandom_range(0, 7) == 0);
            send(rd, sl, pf, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, -1, -1);
            repeat ($urandom_range(0, 2)) do_read("rand_rd");
            if ($urandom_range(0, 5) == 0) do_clr("rand_clr");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Parametrised oversampling UART receiver for the CPU peripheral bus.
- Successor to the single-byte receiver: configurable data width, oversample ratio, stop-bit count and FIFO depth.
- Adds glitch rejection on the start bit, framing and overrun detection, and a first-word-fall-through receive FIFO.
- Sits between the external UARTRx pin and the UART control/status registers.

Parameters:
DATA_W, 8, data bits per frame (5..9), LSB first on the line
OVERSAMPLE, 16, baud_tick strobes per bit period (even, >=4)
STOP_BITS, 1, stop bits checked per frame (1 or 2)
FIFO_DEPTH, 4, receive FIFO entries (power of 2, >=2)
PARITY_ODD, 0, parity sense when UART_RX_PARITY_EN is defined (0=even, 1=odd)

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-low reset
baud_tick  input  1  one-clk strobe at OVERSAMPLE x baud rate
rx_en  input  1  receive enable (uart_con[1])
uart_rx  input  1  serial line, idle high, asynchronous
rd_en  input  1  pop FIFO head
err_clr  input  1  clear sticky error flags
rx_data  output  DATA_W  FIFO head data (UART_RXD)
rx_valid  output  1  FIFO non-empty (uart_con[3])
rx_count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy
frame_err  output  1  sticky: stop bit sampled low
parity_err  output  1  sticky: parity mismatch
overrun  output  1  sticky: frame dropped, FIFO full

Behaviour:
- Reset (reset==0 at posedge clk): all outputs 0, FIFO empty, FSM IDLE, sync flops 1, counters 0.
- Input sync: uart_rx passes through a 2-flop synchroniser (rx_s). Line-to-FSM latency is 2 clk.
- The FSM and tick counter (tcnt) advance only on clk edges where baud_tick==1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: rx_s==0 && rx_en -> START, tcnt=0.
- START: at tcnt==OVERSAMPLE/2-1, sample rx_s.
  - rx_s==1: glitch; return to IDLE, no flags.
  - rx_s==0: tcnt=0, bit index=0 -> DATA.
- DATA: at tcnt==OVERSAMPLE-1 (mid-bit), shift rx_s into bit[index] and reset tcnt. After bit DATA_W-1 -> PARITY if enabled, else STOP.
- PARITY: sample at mid-bit. Mismatch marks the frame bad.
- STOP: sample at mid-bit per stop bit.
  - Any low sample: set frame_err and discard the word.
  - After the last stop sample: -> IDLE immediately (mid stop bit), so back-to-back frames are accepted.
- Frame acceptance: good frame with FIFO not full -> pushed on that clk. Good frame with FIFO full and no rd_en that clk -> word dropped, overrun=1.
- Parity-bad frame: discarded, parity_err=1.
- FIFO is first-word-fall-through:
  - rx_data = head entry while rx_valid; rx_data = 0 when empty.
  - rd_en && rx_valid pops; rd_en on empty is ignored.
  - Push and pop in the same clk: both occur, count unchanged. This holds at full too, with no overrun.
  - Pointers wrap modulo FIFO_DEPTH.
  - rx_valid and rx_count update the clk after a push or pop.
- Sticky flags: cleared by err_clr. A new error in the same clk as err_clr wins (flag stays 1).
- rx_en only gates start detection. Deasserting it mid-frame lets the current frame complete.
- Synchronous reset mid-frame aborts the frame and empties the FIFO.

Optional Feature:
UART_RX_PARITY_EN
- Defined: PARITY state present. One parity bit follows the data bits, checked against PARITY_ODD; parity_err is live.
- Undefined: no PARITY state; DATA goes directly to STOP; parity_err is tied 0.

Test Plan:
- Defaults, line sends 0x5A (8N1, 16 ticks/bit) -> rx_valid=1 after stop mid-bit, rx_data=0x5A, rx_count=1; rd_en pulse -> rx_valid=0, rx_data=0.
- Start glitch low for 4 ticks then high -> FSM back to IDLE; no push, no flags.
- Frame 0x33 with stop bit held low -> frame_err=1, rx_count unchanged; err_clr -> frame_err=0.
- Five back-to-back frames 0x01..0x05, no reads (FIFO_DEPTH=4) -> rx_count=4, overrun=1, pops return 0x01,0x02,0x03,0x04.
- FIFO full, 5th frame completes on the clk rd_en is high -> pop 0x01 and push 0x05 together, rx_count=4, overrun=0.
- UART_RX_PARITY_EN defined, PARITY_ODD=0, 0x07 sent with parity bit 0 -> parity_err=1, no push; same frame with parity 1 -> rx_data=0x07.
